// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, error-code bit positions
// and the default inter-edge timeout.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        DONE   = 3'd4
    } ps2_state_t;

    localparam int ERR_PARITY_BIT = 0;
    localparam int ERR_STOP_BIT   = 1;

    // 200us at 100MHz between mouse-clock falling edges inside a frame
    localparam int PS2_TIMEOUT = 20000;

endpackage

// File: rtl/mouse_receiver_if.sv
// Bus between the PS/2 receiver and the mouse master: raw PS/2 lines and
// read enable in, received byte, error code and ready strobe out.
interface mouse_receiver_if;

    logic       CLK_MOUSE_IN;
    logic       DATA_MOUSE_IN;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;

    // Master side: drives the lines/enable, consumes the received byte
    modport master (
        output CLK_MOUSE_IN,
        output DATA_MOUSE_IN,
        output READ_ENABLE,
        input  BYTE_READ,
        input  BYTE_ERROR_CODE,
        input  BYTE_READY
    );

    // Receiver side
    modport slave (
        input  CLK_MOUSE_IN,
        input  DATA_MOUSE_IN,
        input  READ_ENABLE,
        output BYTE_READ,
        output BYTE_ERROR_CODE,
        output BYTE_READY
    );

endinterface

// File: rtl/ps2_edge_sync.sv
// Two-flop synchroniser for the PS/2 clock and data lines, plus a
// registered one-cycle pulse on each falling edge of the synchronised
// clock. data_o is aligned with fall_o so the bit can be taken in the
// same cycle the pulse is seen.
module ps2_edge_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic fall_o,
    output logic data_o
);

    logic [1:0] clk_meta_q;
    logic       clk_prev_q;
    logic       fall_q;
    logic [1:0] data_meta_q;
    logic       data_q;

    // Clock path: idle-high reset value so leaving reset never fakes an edge
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_meta_q <= 2'b11;
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            clk_meta_q <= {clk_meta_q[0], ps2_clk_i};
            clk_prev_q <= clk_meta_q[1];
            fall_q     <= clk_prev_q & ~clk_meta_q[1];
        end
    end

    // Data path: synchronised and delayed one extra flop to line up with fall_q
    always_ff @(posedge CLK) begin
        data_meta_q <= {data_meta_q[0], ps2_data_i};
        data_q      <= data_meta_q[1];
    end

    assign fall_o = fall_q;
    assign data_o = data_q;

endmodule

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host byte receiver. Deframes start/8 data/odd parity/stop
// frames from the mouse lines and hands each byte plus error flags to the
// mouse master as a one-cycle strobe. Never drives the PS/2 lines.
module mouse_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT = PS2_TIMEOUT
) (
    input  logic              CLK,
    input  logic              RESET,
    mouse_receiver_if.slave   bus
);

    logic       fall;
    logic       data;

    ps2_state_t state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic       par_err_q, par_err_d;
    logic       stop_err_q, stop_err_d;
    logic [7:0] byte_q, byte_d;
    logic [1:0] err_q, err_d;
    logic       ready_q, ready_d;
    logic       in_frame;
    logic       timeout;
    logic       start;

    ps2_edge_sync u_sync (
        .CLK        (CLK),
        .RESET      (RESET),
        .ps2_clk_i  (bus.CLK_MOUSE_IN),
        .ps2_data_i (bus.DATA_MOUSE_IN),
        .fall_o     (fall),
        .data_o     (data)
    );

    // Timeout only applies while a frame is in flight; it beats a same-cycle edge
    assign in_frame = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);
    assign timeout  = in_frame && (tcnt_q == 16'(TIMEOUT));
    assign start    = fall && bus.READ_ENABLE && !data;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DATA;
            DATA: begin
                if (timeout)                        state_d = IDLE;
                else if (fall && bitcnt_q == 3'd7)  state_d = PARITY;
            end
            PARITY: begin
                if (timeout)   state_d = IDLE;
                else if (fall) state_d = STOP;
            end
            STOP: begin
                if (timeout)   state_d = IDLE;
                else if (fall) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        byte_d     = byte_q;
        err_d      = err_q;
        ready_d    = 1'b0;
        tcnt_d     = (in_frame && !fall) ? tcnt_q + 16'd1 : 16'd0;
        case (state_q)
            IDLE: if (start) bitcnt_d = 3'd0;
            DATA: begin
                if (fall && !timeout) begin
                    shift_d[bitcnt_q] = data;
                    bitcnt_d          = bitcnt_q + 3'd1;
                end
            end
            PARITY: if (fall && !timeout) par_err_d = (data != ~^shift_q);
            STOP:   if (fall && !timeout) stop_err_d = ~data;
            DONE: begin
                byte_d                 = shift_q;
                err_d[ERR_PARITY_BIT]  = par_err_q;
                err_d[ERR_STOP_BIT]    = stop_err_q;
                ready_d                = 1'b1;
            end
            default: ;
        endcase
    end

    // Control and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bitcnt_q <= 3'd0;
            tcnt_q   <= 16'd0;
            byte_q   <= 8'h00;
            err_q    <= 2'b00;
            ready_q  <= 1'b0;
        end else begin
            bitcnt_q <= bitcnt_d;
            tcnt_q   <= tcnt_d;
            byte_q   <= byte_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    // Frame data registers, only meaningful once a frame is underway
    always_ff @(posedge CLK) begin
        shift_q    <= shift_d;
        par_err_q  <= par_err_d;
        stop_err_q <= stop_err_d;
    end

    assign bus.BYTE_READ       = byte_q;
    assign bus.BYTE_ERROR_CODE = err_q;
    assign bus.BYTE_READY      = ready_q;

endmodule
